dll_lock_ctrl: RTL
==================

DLL_LOCK_CTRL -- requirements
Module: dll_lock_ctrl

Interface
REQ-001 Parameter L, 16: fine shift-register length; fine mirror range is 0..L.
REQ-002 Parameter M, 16: coarse shift-register length; coarse mirror range is 0..M.
REQ-003 Parameter SETTLE, 4: idle cycles after each step before the next phase-detector sample is accepted.
REQ-004 Parameter LOCK_CNT, 3: consecutive fine direction reversals that declare lock.
REQ-005 Parameter LOSS_CNT, 4: consecutive same-direction fine steps in LOCKED that drop lock.
REQ-006 clk  in  1  single clock; all state updates on the rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 start  in  1  level; 1 = run acquisition, 0 = return to IDLE.
REQ-009 pd_valid  in  1  phase-detector sample strobe, one cycle.
REQ-010 pd_late  in  1  1 = more delay needed; qualified by pd_valid.
REQ-011 comp_in  out  1  fine step direction, 1 = increment.
REQ-012 fine_en  out  1  one-cycle fine step pulse.
REQ-013 up  out  1  coarse step direction, 1 = increment.
REQ-014 coarse_en  out  1  one-cycle coarse step pulse.
REQ-015 locked  out  1  lock indication.
REQ-016 sat  out  1  sticky saturation flag; a step was suppressed at a range limit.
REQ-017 fine_pos  out  $clog2(L+1)  mirror of the fine code.
REQ-018 coarse_pos  out  $clog2(M+1)  mirror of the coarse code.

Function
REQ-019 States: IDLE, COARSE, SETTLE_C, FINE, SETTLE_F, LOCKED. Transitions:
- IDLE -> COARSE when start=1.
- COARSE: on pd_valid, issue a coarse step in direction pd_late, then go to SETTLE_C.
- COARSE -> FINE when the current pd_late differs from the previous coarse sample; no step is issued on that sample.
- SETTLE_C -> COARSE after SETTLE cycles.
- FINE: on pd_valid, issue a fine step, then go to SETTLE_F.
- SETTLE_F -> FINE after SETTLE cycles; SETTLE_F -> LOCKED once the reversal count reaches LOCK_CNT.
- LOCKED keeps issuing fine steps on pd_valid, with a SETTLE wait after each step.
- LOCKED -> FINE after LOSS_CNT consecutive same-direction steps; locked falls in the same cycle.
REQ-020 Step pulse rules:
- fine_en and coarse_en are registered and are never high in the same cycle.
- Each pulse lasts exactly one cycle, in the cycle after the accepted pd_valid.
- comp_in/up are valid in the cycle the pulse is high and hold their last value otherwise.
REQ-021 Reversal counter: increments when a fine step direction differs from the previous fine step; resets to 0 on a same-direction step.
REQ-022 Fine mirror increment: fine_pos increments; L -> 0 wraps with coarse_pos+1 (carry), matching the shift-register chain.
REQ-023 Fine mirror decrement: fine_pos decrements; 0 -> L wraps with coarse_pos-1 (borrow).
REQ-024 Saturation: a step that would move coarse_pos beyond 0..M, directly or via carry/borrow, is suppressed (no pulse); sat sets and the FSM still advances as if stepped.
REQ-025 pd_valid arriving in SETTLE_C, SETTLE_F, IDLE, or in the pulse cycle is ignored.
REQ-026 start deasserted in any state goes to IDLE on the next edge. Positions are retained, locked clears, and no pulse is issued.
REQ-027 sat clears only on reset or on the IDLE -> COARSE transition.

Reset
REQ-028 While rst_n=0, asynchronously force:
- state IDLE
- fine_en=0, coarse_en=0, comp_in=0, up=0
- locked=0, sat=0
- fine_pos=0, coarse_pos=0
- settle counter, reversal counter and loss counter = 0
REQ-029 Reset mid-operation discards any pending step; the first possible pulse is two cycles after start is sampled high following deassertion.

Structure
REQ-030 The state enum and the default values of L, M, SETTLE, LOCK_CNT and LOSS_CNT live in the shared package dll_pkg.
REQ-031 The fine/coarse mirror with carry/borrow and saturation is one sub-module, dll_pos_mirror; the FSM and counters stay in dll_lock_ctrl.

Verification (L=M=16, SETTLE=4, LOCK_CNT=3, LOSS_CNT=4)
REQ-032 Coarse search: start=1, pd_late=1 for 3 samples, then pd_late=0 -> 3 coarse_en pulses with up=1, coarse_pos=3, state FINE, no fine_en.
REQ-033 Lock: in FINE, alternate pd_late 1,0,1,0 -> 4 fine_en pulses with comp_in alternating; locked=1 after the third reversal's settle period.
REQ-034 Carry: fine_pos=16, coarse_pos=2, fine step up -> fine_pos=0, coarse_pos=3, one fine_en pulse, no coarse_en.
REQ-035 Saturation: coarse_pos=0, coarse step down requested -> no coarse_en, sat=1, coarse_pos stays 0.
REQ-036 Loss of lock: in LOCKED, pd_late=1 for 4 samples -> locked falls after the fourth step, state FINE.
REQ-037 Settle window and reset: pd_valid during SETTLE_F produces no pulse; rst_n low mid-SETTLE_C -> all outputs 0 immediately.

Source files
------------

// File: rtl/dll_pkg.sv
// Shared types and default parameters for the DLL lock controller.
package dll_pkg;

    localparam int unsigned L_DEF        = 16;
    localparam int unsigned M_DEF        = 16;
    localparam int unsigned SETTLE_DEF   = 4;
    localparam int unsigned LOCK_CNT_DEF = 3;
    localparam int unsigned LOSS_CNT_DEF = 4;

    typedef enum logic [2:0] {
        StIdle,
        StCoarse,
        StSettleC,
        StFine,
        StSettleF,
        StLocked
    } dll_state_e;

    // Width of a counter that must hold 0..n; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/dll_lock_ctrl_if.sv
// Phase-detector inputs, step outputs and position mirrors of the DLL lock controller.
interface dll_lock_ctrl_if
    import dll_pkg::*;
#(
    parameter int unsigned L = L_DEF,
    parameter int unsigned M = M_DEF
);
    localparam int unsigned FW = $clog2(L + 1);
    localparam int unsigned CW = $clog2(M + 1);

    logic          start;
    logic          pd_valid;
    logic          pd_late;
    logic          comp_in;
    logic          fine_en;
    logic          up;
    logic          coarse_en;
    logic          locked;
    logic          sat;
    logic [FW-1:0] fine_pos;
    logic [CW-1:0] coarse_pos;

    modport master (
        output start, pd_valid, pd_late,
        input  comp_in, fine_en, up, coarse_en, locked, sat, fine_pos, coarse_pos
    );

    modport slave (
        input  start, pd_valid, pd_late,
        output comp_in, fine_en, up, coarse_en, locked, sat, fine_pos, coarse_pos
    );
endinterface

// File: rtl/dll_pos_mirror.sv
// Mirror of the fine/coarse delay-line codes with carry/borrow and range saturation.
module dll_pos_mirror
    import dll_pkg::*;
#(
    parameter int unsigned L = L_DEF,
    parameter int unsigned M = M_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fine_req,
    input  logic                     coarse_req,
    input  logic                     dir,
    input  logic                     sat_clr,
    output logic                     step_ok,
    output logic [$clog2(L+1)-1:0]   fine_pos,
    output logic [$clog2(M+1)-1:0]   coarse_pos,
    output logic                     sat
);
    localparam int unsigned FW = $clog2(L + 1);
    localparam int unsigned CW = $clog2(M + 1);
    localparam logic [FW-1:0] FineMax   = FW'(L);
    localparam logic [CW-1:0] CoarseMax = CW'(M);

    logic [FW-1:0] fine_q, fine_d;
    logic [CW-1:0] coarse_q, coarse_d;
    logic          sat_q, sat_d;
    logic          wrap_up, wrap_dn, fine_ok, coarse_ok;

    // Legality of the requested step and next mirror values.
    always_comb begin
        wrap_up   = dir && (fine_q == FineMax);
        wrap_dn   = !dir && (fine_q == '0);
        fine_ok   = !(wrap_up && coarse_q == CoarseMax) && !(wrap_dn && coarse_q == '0);
        coarse_ok = dir ? (coarse_q != CoarseMax) : (coarse_q != '0);
        step_ok   = fine_req ? fine_ok : coarse_ok;

        fine_d   = fine_q;
        coarse_d = coarse_q;
        sat_d    = sat_q;
        if (sat_clr) begin
            sat_d = 1'b0;
        end else if ((fine_req || coarse_req) && !step_ok) begin
            sat_d = 1'b1;
        end
        if (fine_req && fine_ok) begin
            // Fine chain end rolls into the next coarse tap, as the shift registers do.
            if (wrap_up) begin
                fine_d   = '0;
                coarse_d = coarse_q + 1'b1;
            end else if (wrap_dn) begin
                fine_d   = FineMax;
                coarse_d = coarse_q - 1'b1;
            end else begin
                fine_d = dir ? fine_q + 1'b1 : fine_q - 1'b1;
            end
        end else if (coarse_req && coarse_ok) begin
            coarse_d = dir ? coarse_q + 1'b1 : coarse_q - 1'b1;
        end
    end

    // Mirror and saturation registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fine_q   <= '0;
            coarse_q <= '0;
            sat_q    <= 1'b0;
        end else begin
            fine_q   <= fine_d;
            coarse_q <= coarse_d;
            sat_q    <= sat_d;
        end
    end

    assign fine_pos   = fine_q;
    assign coarse_pos = coarse_q;
    assign sat        = sat_q;
endmodule

// File: rtl/dll_lock_ctrl.sv
// DLL lock controller: coarse search, fine tracking, lock detection and loss of lock.
module dll_lock_ctrl
    import dll_pkg::*;
#(
    parameter int unsigned L        = L_DEF,
    parameter int unsigned M        = M_DEF,
    parameter int unsigned SETTLE   = SETTLE_DEF,
    parameter int unsigned LOCK_CNT = LOCK_CNT_DEF,
    parameter int unsigned LOSS_CNT = LOSS_CNT_DEF
) (
    input logic            clk,
    input logic            rst_n,
    dll_lock_ctrl_if.slave bus
);
    localparam int unsigned SW = cnt_width(SETTLE);
    localparam int unsigned RW = cnt_width(LOCK_CNT);
    localparam int unsigned LW = cnt_width(LOSS_CNT);
    localparam logic [SW-1:0] SettleLd = SW'(SETTLE);
    localparam logic [RW-1:0] LockThr  = RW'(LOCK_CNT);
    localparam logic [LW-1:0] LossThr  = LW'(LOSS_CNT);

    dll_state_e    state_q, state_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [RW-1:0] rev_q, rev_d, rev_next;
    logic [LW-1:0] loss_q, loss_d, loss_next;
    logic          first_q, first_d;      // no earlier sample in this phase to compare with
    logic          last_dir_q, last_dir_d;
    logic          fine_en_q, coarse_en_q, comp_in_q, up_q;
    logic          fine_req, coarse_req, sat_clr, step_ok;
    logic          start, pd_valid, pd_late;

    assign start    = bus.start;
    assign pd_valid = bus.pd_valid;
    assign pd_late  = bus.pd_late;

    // Reversal and same-direction run lengths if a fine step in direction pd_late is taken.
    always_comb begin
        if (first_q || pd_late == last_dir_q) begin
            rev_next = '0;
        end else if (rev_q >= LockThr) begin
            rev_next = rev_q;
        end else begin
            rev_next = rev_q + 1'b1;
        end
        loss_next = (loss_q == '0 || pd_late == last_dir_q) ? loss_q + 1'b1 : LW'(1);
    end

    // Next state, counters and step requests.
    always_comb begin
        state_d    = state_q;
        settle_d   = (settle_q != '0) ? settle_q - 1'b1 : '0;
        rev_d      = rev_q;
        loss_d     = loss_q;
        first_d    = first_q;
        last_dir_d = last_dir_q;
        fine_req   = 1'b0;
        coarse_req = 1'b0;
        sat_clr    = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StCoarse;
                    sat_clr  = 1'b1;
                    first_d  = 1'b1;
                    rev_d    = '0;
                    loss_d   = '0;
                    settle_d = '0;
                end
            end
            StCoarse: begin
                if (pd_valid) begin
                    first_d    = 1'b0;
                    last_dir_d = pd_late;
                    if (!first_q && pd_late != last_dir_q) begin
                        // Phase detector flipped: coarse bracket found, hand over to fine.
                        state_d = StFine;
                        first_d = 1'b1;
                    end else begin
                        coarse_req = 1'b1;
                        settle_d   = SettleLd;
                        state_d    = StSettleC;
                    end
                end
            end
            StSettleC: begin
                if (settle_q <= SW'(1)) state_d = StCoarse;
            end
            StFine: begin
                if (pd_valid) begin
                    fine_req   = 1'b1;
                    settle_d   = SettleLd;
                    first_d    = 1'b0;
                    last_dir_d = pd_late;
                    rev_d      = rev_next;
                    state_d    = StSettleF;
                end
            end
            StSettleF: begin
                if (settle_q <= SW'(1)) begin
                    if (rev_q >= LockThr) begin
                        state_d = StLocked;
                        rev_d   = '0;
                        loss_d  = '0;
                    end else begin
                        state_d = StFine;
                    end
                end
            end
            StLocked: begin
                // Settling is timed in place so locked stays high between steps.
                if (pd_valid && settle_q == '0) begin
                    fine_req   = 1'b1;
                    settle_d   = SettleLd;
                    last_dir_d = pd_late;
                    rev_d      = rev_next;
                    loss_d     = loss_next;
                    if (loss_next >= LossThr) begin
                        state_d = StSettleF;
                        loss_d  = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (!start) begin
            state_d    = StIdle;
            fine_req   = 1'b0;
            coarse_req = 1'b0;
            sat_clr    = 1'b0;
        end
    end

    // FSM and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            settle_q   <= '0;
            rev_q      <= '0;
            loss_q     <= '0;
            first_q    <= 1'b0;
            last_dir_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            rev_q      <= rev_d;
            loss_q     <= loss_d;
            first_q    <= first_d;
            last_dir_q <= last_dir_d;
        end
    end

    // Registered step pulses; directions hold between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fine_en_q   <= 1'b0;
            coarse_en_q <= 1'b0;
            comp_in_q   <= 1'b0;
            up_q        <= 1'b0;
        end else begin
            fine_en_q   <= fine_req & step_ok;
            coarse_en_q <= coarse_req & step_ok;
            if (fine_req && step_ok) comp_in_q <= pd_late;
            if (coarse_req && step_ok) up_q <= pd_late;
        end
    end

    logic [$clog2(L+1)-1:0] fine_pos;
    logic [$clog2(M+1)-1:0] coarse_pos;
    logic                   sat;

    dll_pos_mirror #(
        .L (L),
        .M (M)
    ) u_mirror (
        .clk        (clk),
        .rst_n      (rst_n),
        .fine_req   (fine_req),
        .coarse_req (coarse_req),
        .dir        (pd_late),
        .sat_clr    (sat_clr),
        .step_ok    (step_ok),
        .fine_pos   (fine_pos),
        .coarse_pos (coarse_pos),
        .sat        (sat)
    );

    assign bus.fine_en    = fine_en_q;
    assign bus.coarse_en  = coarse_en_q;
    assign bus.comp_in    = comp_in_q;
    assign bus.up         = up_q;
    assign bus.locked     = (state_q == StLocked);
    assign bus.sat        = sat;
    assign bus.fine_pos   = fine_pos;
    assign bus.coarse_pos = coarse_pos;
endmodule
